// File: rtl/cu_pkg.sv
// Shared control-unit constants: opcode width, the NOP encoding and the
// back-end stage indices used by the control-opcode pipeline.
package cu_pkg;

  localparam int OPCODE_W = 7;
  localparam logic [OPCODE_W-1:0] NOP_OP = '0;

  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

endpackage

// File: rtl/cu_ctrl_stage.sv
// One opcode+valid pipeline register with flush > hold > load priority.
// The caller guarantees d_opcode is NOP_OP whenever d_valid is low.
module cu_ctrl_stage #(
  parameter int              OPW    = 7,
  parameter logic [OPW-1:0]  NOP_OP = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           hold,
  input  logic           d_valid,
  input  logic [OPW-1:0] d_opcode,
  output logic [OPW-1:0] opcode,
  output logic           valid
);

  // NOTE: registers use non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; the chain shifts instead of racing through.
  always_ff @(negedge clk) begin
    if (reset || flush) begin
      opcode <= NOP_OP;
      valid  <= 1'b0;
    end else if (!hold) begin
      opcode <= d_opcode;
      valid  <= d_valid;
    end
  end

endmodule

// File: rtl/cu_ctrl_pipe.sv
// Control-opcode pipeline from decode to write-back: DEPTH stages with
// per-stage stall (bubble insertion), per-stage flush and a retire counter.
module cu_ctrl_pipe #(
  parameter int             OPW    = cu_pkg::OPCODE_W,
  parameter int             DEPTH  = 3,
  parameter logic [OPW-1:0] NOP_OP = OPW'(cu_pkg::NOP_OP),
  parameter int             CNTW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [OPW-1:0]       in_opcode,
  output logic                 in_ready,
  input  logic [DEPTH-1:0]     stall,
  input  logic [DEPTH-1:0]     flush,
  output logic [DEPTH*OPW-1:0] stage_opcode,
  output logic [DEPTH-1:0]     stage_valid,
  output logic [OPW-1:0]       wb_opcode,
  output logic                 wb_valid,
  output logic [CNTW-1:0]      retire_count
);

  // hold[i] is set when stage i or anything downstream of it is stalled.
  logic [DEPTH-1:0] hold;

  // NOTE: hold gets a full default before the chain is built so that no
  // path through this block leaves a bit unassigned and infers a latch.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  assign in_ready = !hold[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic           d_valid;
    logic [OPW-1:0] d_opcode;

    if (g == 0) begin : g_head
      assign d_valid  = in_valid;
      assign d_opcode = in_valid ? in_opcode : NOP_OP;
    end else begin : g_body
      // A frozen upstream stage feeds a bubble rather than a duplicate.
      assign d_valid  = hold[g-1] ? 1'b0   : stage_valid[g-1];
      assign d_opcode = hold[g-1] ? NOP_OP : stage_opcode[(g-1)*OPW +: OPW];
    end

    cu_ctrl_stage #(
      .OPW    (OPW),
      .NOP_OP (NOP_OP)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush[g]),
      .hold     (hold[g]),
      .d_valid  (d_valid),
      .d_opcode (d_opcode),
      .opcode   (stage_opcode[g*OPW +: OPW]),
      .valid    (stage_valid[g])
    );
  end

  assign wb_opcode = stage_opcode[(DEPTH-1)*OPW +: OPW];
  assign wb_valid  = stage_valid[DEPTH-1];

  always_ff @(negedge clk) begin
    if (reset) begin
      retire_count <= '0;
    end else if (wb_valid && !hold[DEPTH-1] && !flush[DEPTH-1]) begin
      retire_count <= retire_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cu_ctrl_pipe.sv
// Self-checking bench for cu_ctrl_pipe: directed scenarios followed by random
// traffic, all compared against a rule-level model of the pipeline.
module tb_cu_ctrl_pipe;

  localparam int OPW   = 7;
  localparam int DEPTH = 3;
  localparam int CNTW  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [OPW-1:0]       in_opcode;
  logic                 in_ready;
  logic [DEPTH-1:0]     stall;
  logic [DEPTH-1:0]     flush;
  logic [DEPTH*OPW-1:0] stage_opcode;
  logic [DEPTH-1:0]     stage_valid;
  logic [OPW-1:0]       wb_opcode;
  logic                 wb_valid;
  logic [CNTW-1:0]      retire_count;

  cu_ctrl_pipe #(
    .OPW    (OPW),
    .DEPTH  (DEPTH),
    .NOP_OP (7'b0000000),
    .CNTW   (CNTW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_opcode    (in_opcode),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .stage_opcode (stage_opcode),
    .stage_valid  (stage_valid),
    .wb_opcode    (wb_opcode),
    .wb_valid     (wb_valid),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: one slot per stage plus an unbounded retire tally.
  logic [OPW-1:0] m_op [DEPTH];
  logic           m_v  [DEPTH];
  int             m_retired;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the rising edge, apply the rules to
  // the model, then compare everything just after the falling (active) edge.
  task automatic step(input logic v, input logic [OPW-1:0] op,
                      input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                      input logic rs);
    logic [OPW-1:0]       n_op [DEPTH];
    logic                 n_v  [DEPTH];
    logic [DEPTH-1:0]     h;
    logic [DEPTH*OPW-1:0] exp_op;
    logic [DEPTH-1:0]     exp_v;
    @(posedge clk);
    reset = rs; in_valid = v; in_opcode = op; stall = st; flush = fl;
    #1;
    for (int i = 0; i < DEPTH; i++) h[i] = |(st >> i);
    check("in_ready", 32'(in_ready), 32'(!h[0]));

    if (rs) m_retired = 0;
    else if (m_v[DEPTH-1] && !h[DEPTH-1] && !fl[DEPTH-1]) m_retired++;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs || fl[i])      begin n_op[i] = '0;        n_v[i] = 1'b0;       end
      else if (h[i])        begin n_op[i] = m_op[i];   n_v[i] = m_v[i];     end
      else if (i == 0)      begin n_op[i] = v ? op : '0; n_v[i] = v;        end
      else if (h[i-1])      begin n_op[i] = '0;        n_v[i] = 1'b0;       end
      else                  begin n_op[i] = m_op[i-1]; n_v[i] = m_v[i-1];   end
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_op[i] = n_op[i];
      m_v[i]  = n_v[i];
      exp_op[i*OPW +: OPW] = n_op[i];
      exp_v[i] = n_v[i];
    end

    @(negedge clk);
    #1;
    check("stage_opcode", 32'(stage_opcode), 32'(exp_op));
    check("stage_valid",  32'(stage_valid),  32'(exp_v));
    check("wb_opcode",    32'(wb_opcode),    32'(m_op[DEPTH-1]));
    check("wb_valid",     32'(wb_valid),     32'(m_v[DEPTH-1]));
    check("retire_count", 32'(retire_count), 32'(m_retired % (1 << CNTW)));
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic accept(input logic [OPW-1:0] op);
    step(1'b1, op, '0, '0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; stall = '0; flush = '0;
    for (int i = 0; i < DEPTH; i++) begin m_op[i] = '0; m_v[i] = 1'b0; end
    m_retired = 0;

    // Reset state and straight-line streaming.
    do_reset();
    check("rst_valid", 32'(stage_valid), 32'h0);
    check("rst_count", 32'(retire_count), 32'h0);
    accept(7'h33); accept(7'h13); accept(7'h03);
    check("wb_first", 32'({wb_valid, wb_opcode}), 32'({1'b1, 7'h33}));
    idle();
    check("wb_second", 32'({wb_valid, wb_opcode}), 32'({1'b1, 7'h13}));
    idle();
    check("wb_third", 32'({wb_valid, wb_opcode}), 32'({1'b1, 7'h03}));
    idle();
    check("retire_3", 32'(retire_count), 32'd3);

    // stall[1] for two cycles with 0x13 in stage 1.
    do_reset();
    accept(7'h33); accept(7'h13); accept(7'h23);
    step(1'b1, 7'h55, 3'b010, '0, 1'b0);
    check("stall_s1_op", 32'(stage_opcode[OPW +: OPW]), 32'h13);
    check("stall_bubble1", 32'(stage_valid), 32'b011);
    step(1'b1, 7'h55, 3'b010, '0, 1'b0);
    check("stall_bubble2", 32'(stage_valid), 32'b011);
    check("stall_count", 32'(retire_count), 32'd1);
    idle(); idle(); idle();

    // flush stages 0 and 1; stage 2 still loads stage 1's pre-edge entry.
    do_reset();
    accept(7'h11); accept(7'h63); accept(7'h23);
    step(1'b0, '0, '0, 3'b011, 1'b0);
    check("flush_valid", 32'(stage_valid), 32'b100);
    check("flush_s01_op", 32'(stage_opcode[2*OPW-1:0]), 32'h0);
    idle(); idle();

    // stall[2] and flush[2] together on a valid WB entry.
    do_reset();
    accept(7'h6F); idle(); idle();
    check("wb_6f", 32'({wb_valid, wb_opcode}), 32'({1'b1, 7'h6F}));
    step(1'b0, '0, 3'b100, 3'b100, 1'b0);
    check("stall_flush_wb", 32'({wb_valid, wb_opcode}), 32'h0);
    check("stall_flush_cnt", 32'(retire_count), 32'd0);

    // Reset with a full pipe discards everything, including the new accept.
    accept(7'h01); accept(7'h02); accept(7'h03); accept(7'h04);
    step(1'b1, 7'h7A, '0, '0, 1'b1);
    check("midrst_valid", 32'(stage_valid), 32'h0);
    check("midrst_op", 32'(stage_opcode), 32'h0);
    check("midrst_cnt", 32'(retire_count), 32'h0);

    // 17 retirements wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) accept(7'(i + 1));
    idle(); idle(); idle();
    check("wrap_count", 32'(retire_count), 32'd1);

    // Random traffic, including invalid offers carrying non-NOP opcodes.
    for (int n = 0; n < 1500; n++) begin
      logic [DEPTH-1:0] st, fl;
      for (int i = 0; i < DEPTH; i++) begin
        st[i] = ($urandom % 6) == 0;
        fl[i] = ($urandom % 10) == 0;
      end
      step(($urandom % 4) != 0, 7'($urandom), st, fl, ($urandom % 100) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
